// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response channel plus the decode-facing queue head.
// The master modport is the fetch unit; the slave modport is memory and decode.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch front end: credit-limited pipelined imem requests, in-order {pc, instr} queue, flush/redirect.
// Response reaches the queue head one cycle later; requests stall when outstanding + queued fills QDEPTH.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'('h100),
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redir_valid,
    input  logic            redir_rel,
    input  logic [XLEN-1:0] redir_pc,
    input  logic [XLEN-1:0] redir_imm,
    input  logic            trap_valid,
    pc_fetch_unit_if.master bus,
    output logic [XLEN-1:0] pc_current,
    output logic            misalign_err
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(QDEPTH);

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   drop_cnt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] pc_mem   [QDEPTH];
    logic [ILEN-1:0] data_mem [QDEPTH];

    logic            flush;
    logic            tgt_misaligned;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] flush_tgt;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;

    always_comb begin
        flush          = trap_valid || redir_valid;
        redir_tgt      = redir_rel ? (redir_pc + redir_imm) : redir_imm;
        tgt_misaligned = redir_valid && !trap_valid && (redir_tgt[1:0] != 2'b00);
        flush_tgt      = (trap_valid || tgt_misaligned) ? TRAP_PC : redir_tgt;
        credit_used    = {1'b0, outstanding} + {1'b0, q_count};
    end

    // Gating with reset keeps the request low while reset is held, independent of clocking.
    assign bus.imem_req_valid = reset && !flush && (credit_used < DEPTH_LIM);
    assign bus.imem_req_addr  = pc_current;
    assign bus.instr_valid    = (q_count != '0);
    assign bus.instr          = data_mem[rd_ptr];
    assign bus.instr_pc       = pc_mem[rd_ptr];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid;
    assign push     = rsp_fire && (drop_cnt == '0) && !flush;
    assign pop      = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_current   <= RESET_PC;
            rsp_pc       <= RESET_PC;
            outstanding  <= '0;
            q_count      <= '0;
            drop_cnt     <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= tgt_misaligned;
            outstanding  <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (flush) begin
                pc_current <= flush_tgt;
                rsp_pc     <= flush_tgt;
                q_count    <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                // Everything still in flight belongs to the abandoned path.
                drop_cnt   <= outstanding - CW'(rsp_fire);
            end else begin
                if (req_fire) pc_current <= pc_current + XLEN'(4);
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                q_count <= q_count + CW'(push) - CW'(pop);
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: in-order memory model, epoch-tagged transaction model, directed and random phases.
module tb_pc_fetch_unit;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] TRAP_PC  = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redir_valid = 1'b0;
    logic        redir_rel = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] redir_imm = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] pc_current;
    logic        misalign_err;

    pc_fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

    pc_fetch_unit #(
        .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .redir_valid(redir_valid), .redir_rel(redir_rel),
        .redir_pc(redir_pc), .redir_imm(redir_imm), .trap_valid(trap_valid),
        .bus(bus), .pc_current(pc_current), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] m_q[$];
    logic [31:0] m_pc = RESET_PC;
    logic        m_mis = 1'b0;
    int          m_epoch = 0;

    logic        k_ready = 0, k_rsp = 0, k_iready = 0, k_redir = 0, k_rel = 0, k_trap = 0;
    logic [31:0] k_rpc = '0, k_imm = '0;

    logic [31:0] pops[$];
    logic [31:0] req_addrs[$];
    int          req_fires = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_flush();
        k_redir = 0;
        k_trap  = 0;
    endtask

    // One clock cycle: drive knobs, compare at negedge, then advance memory and model.
    task automatic step();
        logic        flush, exp_rv, rsp_v;
        logic [31:0] tgt, tmp;
        mreq_t       rsp_r, req_r;
        redir_valid = k_redir; redir_rel = k_rel; redir_pc = k_rpc; redir_imm = k_imm;
        trap_valid  = k_trap;
        bus.imem_req_ready = k_ready;
        bus.instr_ready    = k_iready;
        rsp_v = k_rsp && (mem_q.size() != 0);
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = '0;
        if (rsp_v) bus.imem_rsp_data = mem_data(mem_q[0].addr);

        @(negedge clk);
        flush  = k_trap || k_redir;
        exp_rv = !flush && ((mem_q.size() + m_q.size()) < QDEPTH);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("pc_current", pc_current, m_pc);
        chk("instr_valid", bus.instr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("instr_pc", bus.instr_pc, m_q[0]);
            chk("instr", bus.instr, mem_data(m_q[0]));
        end
        chk("misalign_err", misalign_err, m_mis);

        if (bus.instr_valid && k_iready && !flush) pops.push_back(bus.instr_pc);
        rsp_r.addr = '0;
        rsp_r.epoch = -1;
        if (rsp_v) rsp_r = mem_q.pop_front();
        if (bus.imem_req_valid && k_ready) begin
            req_r.addr  = bus.imem_req_addr;
            req_r.epoch = m_epoch;
            mem_q.push_back(req_r);
            req_addrs.push_back(req_r.addr);
            req_fires++;
        end

        m_mis = 1'b0;
        if (flush) begin
            tgt = k_rel ? (k_rpc + k_imm) : k_imm;
            if (k_trap) tgt = TRAP_PC;
            else if (tgt[1:0] != 2'b00) begin
                tgt   = TRAP_PC;
                m_mis = 1'b1;
            end
            m_pc = tgt;
            m_q.delete();
            m_epoch++;
        end else begin
            if (m_q.size() != 0 && k_iready) tmp = m_q.pop_front();
            if (rsp_v && rsp_r.epoch == m_epoch) m_q.push_back(rsp_r.addr);
            if (exp_rv && k_ready) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs react before any clock edge.
    task automatic do_reset();
        #1 reset = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 32'h0);
        chk("rst_instr_valid", bus.instr_valid, 32'h0);
        chk("rst_pc_current", pc_current, 32'h0);
        chk("rst_misalign", misalign_err, 32'h0);
        redir_valid = 0; trap_valid = 0;
        bus.imem_rsp_valid = 0; bus.imem_req_ready = 0; bus.instr_ready = 0;
        clear_flush();
        mem_q.delete();
        m_q.delete();
        m_pc  = RESET_PC;
        m_mis = 1'b0;
        m_epoch++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 0;
        do_reset();

        // Streaming with single-cycle memory: one instruction per cycle once primed.
        k_ready = 1; k_rsp = 1; k_iready = 1;
        pops.delete();
        repeat (12) step();
        chk("t1_pop_count", pops.size(), 32'd10);
        chk("t1_pop0", qat(pops, 0), 32'h0);
        chk("t1_pop1", qat(pops, 1), 32'h4);
        chk("t1_pop2", qat(pops, 2), 32'h8);

        // Decode stalled: credits cap requests at QDEPTH.
        do_reset();
        k_ready = 1; k_rsp = 1; k_iready = 0;
        req_fires = 0;
        repeat (10) step();
        chk("t2_req_count", req_fires, 32'd4);
        chk("t2_pc", pc_current, 32'h10);
        chk("t2_req_held", bus.imem_req_valid, 32'h0);
        req_addrs.delete();
        pops.delete();
        k_iready = 1;
        repeat (6) step();
        chk("t2_resume_addr", qat(req_addrs, 0), 32'h10);
        chk("t2_resume_pop", qat(pops, 0), 32'h0);

        // Relative redirect with two requests in flight.
        do_reset();
        k_ready = 1; k_rsp = 0; k_iready = 1;
        repeat (2) step();
        k_redir = 1; k_rel = 1; k_rpc = 32'h20; k_imm = 32'h40;
        step();
        clear_flush();
        chk("t3_pc", pc_current, 32'h60);
        k_rsp = 1;
        pops.delete();
        repeat (8) step();
        chk("t3_first_pop", qat(pops, 0), 32'h60);

        // Trap wins over a simultaneous redirect.
        k_trap = 1; k_redir = 1; k_rel = 0; k_imm = 32'h40;
        step();
        clear_flush();
        chk("t4_pc", pc_current, 32'h100);
        chk("t4_no_misalign", misalign_err, 32'h0);

        // Misaligned absolute target.
        k_redir = 1; k_rel = 0; k_imm = 32'h202;
        step();
        clear_flush();
        chk("t5_pc", pc_current, 32'h100);
        chk("t5_misalign", misalign_err, 32'h1);
        step();
        chk("t5_misalign_drop", misalign_err, 32'h0);

        // Sequential wrap past the top of the address space.
        k_redir = 1; k_rel = 0; k_imm = 32'hFFFF_FFF8;
        step();
        clear_flush();
        pops.delete();
        repeat (8) step();
        chk("wrap_pop0", qat(pops, 0), 32'hFFFF_FFF8);
        chk("wrap_pop1", qat(pops, 1), 32'hFFFF_FFFC);
        chk("wrap_pop2", qat(pops, 2), 32'h0);

        // Reset mid-stream with requests in flight and entries queued.
        k_iready = 0; k_rsp = 0;
        repeat (4) step();
        k_rsp = 1;
        repeat (2) step();
        do_reset();
        k_ready = 1; k_rsp = 1; k_iready = 1;
        req_addrs.delete();
        repeat (3) step();
        chk("t6_restart_addr", qat(req_addrs, 0), RESET_PC);

        // Randomized traffic with occasional redirects, traps and one reset.
        for (int i = 0; i < 3000; i++) begin
            k_ready  = $urandom_range(0, 9) < 7;
            k_rsp    = $urandom_range(0, 9) < 7;
            k_iready = $urandom_range(0, 9) < 7;
            k_trap   = $urandom_range(0, 99) < 1;
            k_redir  = $urandom_range(0, 99) < 4;
            k_rel    = 1'($urandom_range(0, 1));
            k_rpc    = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 9))
                0:       k_imm = $urandom;
                1:       begin k_imm = 32'hFFFF_FFF0; k_rel = 0; end
                default: k_imm = $urandom_range(0, 255) * 4;
            endcase
            step();
            if (i == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
